// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry FIFO of lane-placed stores, drained one per cycle into four byte banks.
// Define STORE_FWD_EN to add the combinational store-to-load forwarding search (ld_addr/fwd_* ports).
`ifndef MEMORY_BITS
`define MEMORY_BITS 16
`endif
`ifndef BYTE
`define BYTE 2'd0
`endif
`ifndef HALFWORD
`define HALFWORD 2'd1
`endif
`ifndef WORD
`define WORD 2'd2
`endif

module store_buffer #(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = `MEMORY_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [31:0]               st_addr,
  input  logic [31:0]               st_data,
  input  logic [1:0]                st_type,
  output logic                      misaligned,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic [ADDR_BITS-3:0]      mem_word_addr,
  output logic [3:0]                mem_be,
  output logic [31:0]               mem_wdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
`ifdef STORE_FWD_EN
  ,
  input  logic [31:0]               ld_addr,
  output logic                      fwd_hit,
  output logic [3:0]                fwd_be,
  output logic [31:0]               fwd_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_BITS - 2;

  // be[j] enables data byte [8j+7:8j]; lane k (address offset k) is byte 3-k.
  function automatic logic [35:0] place_lanes(input logic [1:0] typ, input logic [1:0] off,
                                              input logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] lanes;
    be    = 4'b0000;
    lanes = 32'h0000_0000;
    case (typ)
      `BYTE: begin
        be    = 4'b1000 >> off;
        lanes = {d[7:0], 24'h00_0000} >> {off, 3'b000};
      end
      `HALFWORD: begin
        be    = off[1] ? 4'b0011 : 4'b1100;
        lanes = off[1] ? {16'h0000, d[15:0]} : {d[15:0], 16'h0000};
      end
      `WORD: begin
        be    = 4'b1111;
        lanes = d;
      end
      default: begin
        be    = 4'b0000;
        lanes = 32'h0000_0000;
      end
    endcase
    return {be, lanes};
  endfunction

  function automatic logic is_aligned(input logic [1:0] typ, input logic [1:0] off);
    logic ok;
    case (typ)
      `BYTE:     ok = 1'b1;
      `HALFWORD: ok = (off[0] == 1'b0);
      `WORD:     ok = (off == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [WA_W-1:0]  word_q [DEPTH];
  logic [WA_W-1:0]  word_d [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [3:0]       be_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misaligned_q, misaligned_d;

  logic             ready_s;
  logic             empty_s;
  logic             aligned_s;
  logic             push_s;
  logic             pop_s;
  logic [35:0]      placed_s;
  logic             unused_s;

  assign ready_s = (count_q != CNT_W'(DEPTH));
  assign empty_s = (count_q == CNT_W'(0));
  assign unused_s = ^{st_addr[31:ADDR_BITS]};

  // Next-state: enqueue at the write pointer, dequeue at the read pointer, track occupancy.
  always_comb begin
    placed_s     = place_lanes(st_type, st_addr[1:0], st_data);
    aligned_s    = is_aligned(st_type, st_addr[1:0]);
    push_s       = st_valid && ready_s && aligned_s;
    pop_s        = !empty_s && mem_ready;
    misaligned_d = st_valid && ready_s && !aligned_s;

    word_d = word_q;
    be_d   = be_q;
    data_d = data_q;
    word_d[wr_ptr_q] = push_s ? st_addr[ADDR_BITS-1:2] : word_q[wr_ptr_q];
    be_d[wr_ptr_q]   = push_s ? placed_s[35:32]        : be_q[wr_ptr_q];
    data_d[wr_ptr_q] = push_s ? placed_s[31:0]         : data_q[wr_ptr_q];

    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards every queued store, including the one being drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q       <= '{default: {WA_W{1'b0}}};
      be_q         <= '{default: 4'b0000};
      data_q       <= '{default: 32'h0000_0000};
      rd_ptr_q     <= {PTR_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      misaligned_q <= 1'b0;
    end else begin
      word_q       <= word_d;
      be_q         <= be_d;
      data_q       <= data_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign st_ready      = ready_s;
  assign empty         = empty_s;
  assign count         = count_q;
  assign misaligned    = misaligned_q;
  assign mem_we        = !empty_s;
  assign mem_word_addr = word_q[rd_ptr_q];
  assign mem_be        = be_q[rd_ptr_q];
  assign mem_wdata     = data_q[rd_ptr_q];

`ifdef STORE_FWD_EN
  logic [3:0]       fwd_be_s;
  logic [31:0]      fwd_data_s;
  logic [PTR_W-1:0] idx_s;
  logic             match_s;
  logic             take_s;
  logic             unused_fwd_s;

  assign unused_fwd_s = ^{ld_addr[31:ADDR_BITS], ld_addr[1:0]};

  // Walk valid entries oldest to youngest so the youngest writer of each byte wins.
  always_comb begin
    fwd_be_s   = 4'b0000;
    fwd_data_s = 32'h0000_0000;
    idx_s      = {PTR_W{1'b0}};
    match_s    = 1'b0;
    take_s     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s   = rd_ptr_q + PTR_W'(i);
      match_s = (CNT_W'(i) < count_q) && (word_q[idx_s] == ld_addr[ADDR_BITS-1:2]);
      for (int j = 0; j < 4; j++) begin
        take_s               = match_s && be_q[idx_s][j];
        fwd_be_s[j]          = take_s ? 1'b1 : fwd_be_s[j];
        fwd_data_s[8*j +: 8] = take_s ? data_q[idx_s][8*j +: 8] : fwd_data_s[8*j +: 8];
      end
    end
  end

  assign fwd_be   = fwd_be_s;
  assign fwd_data = fwd_data_s;
  assign fwd_hit  = |fwd_be_s;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
`timescale 1ns/1ps
`ifndef MEMORY_BITS
`define MEMORY_BITS 16
`endif
`ifndef BYTE
`define BYTE 2'd0
`endif
`ifndef HALFWORD
`define HALFWORD 2'd1
`endif
`ifndef WORD
`define WORD 2'd2
`endif

module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AB    = `MEMORY_BITS;
  localparam int WA    = AB - 2;
  localparam logic [31:0] WMASK = (32'd1 << WA) - 32'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        mem_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_type;
  wire         st_ready;
  wire         misaligned;
  wire         mem_we;
  wire         empty;
  wire [WA-1:0] mem_word_addr;
  wire [3:0]   mem_be;
  wire [31:0]  mem_wdata;
  wire [2:0]   count;
`ifdef STORE_FWD_EN
  logic [31:0] ld_addr;
  wire         fwd_hit;
  wire [3:0]   fwd_be;
  wire [31:0]  fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  bit   model_on = 1'b0;
  logic mis_exp  = 1'b0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_type(st_type), .misaligned(misaligned),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_word_addr(mem_word_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .count(count), .empty(empty)
`ifdef STORE_FWD_EN
    , .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_be(fwd_be), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] t);
    return (t == `BYTE) ? 1 : (t == `HALFWORD) ? 2 : (t == `WORD) ? 4 : 0;
  endfunction

  function automatic bit aligned(input logic [1:0] t, input logic [31:0] a);
    int n;
    n = nbytes(t);
    return (n != 0) && ((int'(a[1:0]) % n) == 0);
  endfunction

  // Byte-by-byte: first stored byte is the value's most significant byte, lane k is byte 3-k.
  function automatic ent_t make_ent(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int n;
    int lane;
    n = nbytes(t);
    e.waddr = (a >> 2) & WMASK;
    e.be    = 4'b0000;
    e.data  = 32'h0000_0000;
    for (int k = 0; k < n; k++) begin
      lane = int'(a[1:0]) + k;
      e.be[3-lane]            = 1'b1;
      e.data[8*(3-lane) +: 8] = d[8*(n-1-k) +: 8];
    end
    return e;
  endfunction

  function automatic logic [35:0] fwd_model(input logic [31:0] la);
    logic [3:0]  b;
    logic [31:0] dd;
    b  = 4'b0000;
    dd = 32'h0000_0000;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].waddr == ((la >> 2) & WMASK)) begin
        for (int k = 0; k < 4; k++) begin
          if (mq[i].be[k]) begin
            b[k]         = 1'b1;
            dd[8*k +: 8] = mq[i].data[8*k +: 8];
          end
        end
      end
    end
    return {b, dd};
  endfunction

  // Reference model advances on the same edge as the DUT.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mis_exp  <= 1'b0;
      model_on <= 1'b1;
    end else if (model_on) begin
      mis_exp <= st_valid && (mq.size() < DEPTH) && !aligned(st_type, st_addr);
      if ((mq.size() > 0) && mem_ready) mq.pop_front();
      if (st_valid && (mq.size() < DEPTH) && aligned(st_type, st_addr))
        mq.push_back(make_ent(st_type, st_addr, st_data));
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (model_on) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
      chk("mem_we", 32'(mem_we), 32'(mq.size() != 0));
      chk("misaligned", 32'(misaligned), 32'(mis_exp));
      if (mq.size() != 0) begin
        chk("mem_word_addr", 32'(mem_word_addr), mq[0].waddr);
        chk("mem_be", 32'(mem_be), 32'(mq[0].be));
        chk("mem_wdata", mem_wdata, mq[0].data);
      end
`ifdef STORE_FWD_EN
      chk("fwd_be", 32'(fwd_be), 32'(fwd_model(ld_addr) >> 32));
      chk("fwd_data", fwd_data, fwd_model(ld_addr) & 36'h0_FFFF_FFFF);
      chk("fwd_hit", 32'(fwd_hit), 32'(|(fwd_model(ld_addr) >> 32)));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    drive(1'b0, `WORD, 32'h0, 32'h0);
`ifdef STORE_FWD_EN
    ld_addr = 32'h0;
`endif
    cyc();
    cyc();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    reset = 1'b0;

    // WORD store, one-cycle latency to mem_we
    mem_ready = 1'b1;
    drive(1'b1, `WORD, 32'h10, 32'h1122_3344);
    cyc();
    drive(1'b0, `WORD, 32'h0, 32'h0);
    chk("w_we", 32'(mem_we), 32'd1);
    chk("w_addr", 32'(mem_word_addr), 32'd4);
    chk("w_be", 32'(mem_be), 32'hF);
    chk("w_data", mem_wdata, 32'h1122_3344);
    cyc();
    chk("w_empty", 32'(empty), 32'd1);

    // BYTE and HALFWORD lane placement
    drive(1'b1, `BYTE, 32'h13, 32'h0000_00AB);
    cyc();
    drive(1'b0, `WORD, 32'h0, 32'h0);
    chk("b_be", 32'(mem_be), 32'h1);
    chk("b_data", mem_wdata, 32'h0000_00AB);
    cyc();
    drive(1'b1, `HALFWORD, 32'h22, 32'h0000_BEEF);
    cyc();
    drive(1'b0, `WORD, 32'h0, 32'h0);
    chk("h_be", 32'(mem_be), 32'h3);
    chk("h_data", mem_wdata, 32'h0000_BEEF);
    cyc();

    // Fill to full with banks stalled; fifth store is refused
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, `WORD, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i));
      cyc();
    end
    drive(1'b0, `WORD, 32'h0, 32'h0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(st_ready), 32'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", mem_wdata, 32'hA000_0000 + 32'(i));
      chk("drain_addr", 32'(mem_word_addr), 32'h40 + 32'(i));
      cyc();
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop keeps count steady
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, `WORD, 32'h80, 32'h5A5A_0000 + 32'(i));
      cyc();
      chk("pp_count", 32'(count), 32'd1);
    end
    drive(1'b0, `WORD, 32'h0, 32'h0);
    cyc();

    // Misaligned stores are rejected with a one-cycle pulse
    drive(1'b1, `HALFWORD, 32'h01, 32'h0000_1234);
    cyc();
    chk("mis1", 32'(misaligned), 32'd1);
    chk("mis1_count", 32'(count), 32'd0);
    drive(1'b1, `WORD, 32'h06, 32'h1234_5678);
    cyc();
    chk("mis2", 32'(misaligned), 32'd1);
    chk("mis2_we", 32'(mem_we), 32'd0);
    drive(1'b0, `WORD, 32'h0, 32'h0);
    cyc();
    chk("mis_clear", 32'(misaligned), 32'd0);

    // Two bytes to the same address, then a halfword in the same word
    mem_ready = 1'b0;
    drive(1'b1, `BYTE, 32'h40, 32'h0000_0055);
    cyc();
    drive(1'b1, `BYTE, 32'h40, 32'h0000_0066);
    cyc();
    drive(1'b0, `WORD, 32'h0, 32'h0);
`ifdef STORE_FWD_EN
    ld_addr = 32'h40;
    #1;
    chk("fwd_hit_lit", 32'(fwd_hit), 32'd1);
    chk("fwd_be_lit", 32'(fwd_be), 32'h8);
    chk("fwd_data_lit", fwd_data, 32'h6600_0000);
`endif
    drive(1'b1, `HALFWORD, 32'h42, 32'h0000_1234);
    cyc();
    drive(1'b0, `WORD, 32'h0, 32'h0);
`ifdef STORE_FWD_EN
    chk("fwd_be_lit2", 32'(fwd_be), 32'hB);
    chk("fwd_data_lit2", fwd_data, 32'h6600_1234);
`endif
    chk("q3_count", 32'(count), 32'd3);

    // Reset with stores still queued
    reset = 1'b1;
    cyc();
    chk("rst2_empty", 32'(empty), 32'd1);
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_we", 32'(mem_we), 32'd0);
    reset = 1'b0;

    // Mixed traffic over a small address window, checked by the model
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
            32'h200 + 32'($urandom_range(0, 15)), $urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
`ifdef STORE_FWD_EN
      ld_addr = 32'h200 + 32'($urandom_range(0, 3) << 2);
`endif
      cyc();
    end
    drive(1'b0, `WORD, 32'h0, 32'h0);
    mem_ready = 1'b1;
    repeat (6) cyc();
    chk("final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
